// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl
// Sequential 8x8 shift-add multiplier. One 8-bit ripple-carry adder is reused
// over eight iterations to build a 16-bit product. This is the small-area
// alternative for the partial products of the complex multiplier.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request, sampled only while idle
//   A, B     multiplicand / multiplier, captured when start is accepted
//   busy     high while running and in the done cycle (registered)
//   done     one-cycle pulse, product valid (registered)
//   product  registered {PH,PL}; holds until the next accepted start
//
// Build option
//   SHIFT_ADD_MULT_SIGNED_EN : treat A and B as two's complement. The
//   magnitudes are multiplied, and on the last iteration the result is negated
//   when the operand signs differ. Latency and handshake are unchanged.

module shift_add_mult_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    logic [7:0]  m_r;
    logic [7:0]  ph_r;
    logic [7:0]  pl_r;
    logic [2:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic        busy_nxt_s;
    logic        done_nxt_s;

    logic [7:0]  addend_s;
    logic [7:0]  sum_s;
    logic        co_s;
    logic [15:0] shift_s;
    logic [15:0] step_s;
    logic        last_s;
    logic [7:0]  load_m_s;
    logic [7:0]  load_pl_s;

    // Ripple-carry adder built from a chain of full adders; returns {co,sum}.
    function automatic logic [8:0] rca8(input logic [7:0] a, input logic [7:0] b,
                                        input logic ci);
        logic [8:0] res;
        logic       c;
        c = ci;
        res = 9'd0;
        for (int i = 0; i < 8; i++) begin
            res[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        res[8] = c;
        return res;
    endfunction

    // The only adder: accumulator plus multiplicand gated by the current
    // multiplier bit.
    assign addend_s        = pl_r[0] ? m_r : 8'h00;
    assign {co_s, sum_s}   = rca8(ph_r, addend_s, 1'b0);

    // 17-bit {co,sum,PL} shifted right by one; co lands in PH[7].
    assign shift_s = {co_s, sum_s, pl_r[7:1]};
    assign last_s  = (state_r == ST_RUN) && (cnt_r == 3'd7);

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    logic sign_r;

    // Two's-complement magnitude; 0x80 maps to 128, which fits unsigned.
    function automatic logic [7:0] abs8(input logic [7:0] x);
        logic [7:0] r;
        if (x[7]) begin
            r = ~x + 8'd1;
        end else begin
            r = x;
        end
        return r;
    endfunction

    assign load_m_s  = abs8(A);
    assign load_pl_s = abs8(B);

    // Apply the sign on the final iteration so {PH,PL} already holds the
    // signed result in the done cycle and afterwards. Negating zero gives zero.
    always_comb begin
        step_s = shift_s;
        if (last_s && sign_r) begin
            step_s = ~shift_s + 16'd1;
        end else begin
            step_s = shift_s;
        end
    end

    // Sign of the result, captured with the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            sign_r <= A[7] ^ B[7];
        end else begin
            sign_r <= sign_r;
        end
    end
`else
    assign load_m_s  = A;
    assign load_pl_s = B;
    assign step_s    = shift_s;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; start outside IDLE is dropped, not queued.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == 3'd7) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode from the next state, so busy/done can be registered
    // and still line up with the state they describe.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (next_state_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
            ST_RUN: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b0;
            end
            ST_DONE: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Datapath: load on accepted start, one shift-add per RUN cycle, hold
    // otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r   <= 8'h00;
            ph_r  <= 8'h00;
            pl_r  <= 8'h00;
            cnt_r <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        m_r   <= load_m_s;
                        ph_r  <= 8'h00;
                        pl_r  <= load_pl_s;
                        cnt_r <= 3'd0;
                    end else begin
                        m_r   <= m_r;
                        ph_r  <= ph_r;
                        pl_r  <= pl_r;
                        cnt_r <= cnt_r;
                    end
                end
                ST_RUN: begin
                    {ph_r, pl_r} <= step_s;
                    cnt_r        <= cnt_r + 3'd1;
                end
                default: begin
                    m_r   <= m_r;
                    ph_r  <= ph_r;
                    pl_r  <= pl_r;
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = {ph_r, pl_r};

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
module tb_shift_add_mult_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int total  = 0;
    int passed = 0;

    shift_add_mult_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    // Count edges from the accepting edge until done is seen (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        int n;
        A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        A = ~a; B = ~b;
        check({tag, "_busy_rise"}, {15'd0, busy}, 16'd1);
        check({tag, "_done_low"},  {15'd0, done}, 16'd0);
        wait_done(n);
        check({tag, "_latency"}, n[15:0], 16'd8);
        check({tag, "_product"}, product, exp);
        tick();
        check({tag, "_busy_fall"}, {15'd0, busy}, 16'd0);
        check({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
        check({tag, "_hold"}, product, exp);
    endtask

    initial begin
        int n;
        int done_seen;
        rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00;
        tick();
        tick();
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_product", product, 16'h0000);
        rst = 1'b0;
        tick();

        run_op("13x11", 8'd13, 8'd11, 16'h008F);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        run_op("ffxff", 8'hFF, 8'hFF, 16'h0001);
        run_op("00xa5", 8'h00, 8'hA5, 16'h0000);
        run_op("80x01", 8'h80, 8'h01, 16'hFF80);
        run_op("ffx02", 8'hFF, 8'h02, 16'hFFFE);
        run_op("80x80", 8'h80, 8'h80, 16'h4000);
        run_op("80x7f", 8'h80, 8'h7F, 16'hC080);
        run_op("00x80", 8'h00, 8'h80, 16'h0000);
`else
        run_op("ffxff", 8'hFF, 8'hFF, 16'hFE01);
        run_op("00xa5", 8'h00, 8'hA5, 16'h0000);
        run_op("80x01", 8'h80, 8'h01, 16'h0080);
        run_op("ffx02", 8'hFF, 8'h02, 16'h01FE);
        run_op("80x80", 8'h80, 8'h80, 16'h4000);
        run_op("80x7f", 8'h80, 8'h7F, 16'h3F80);
        run_op("00x80", 8'h00, 8'h80, 16'h0000);
`endif

        // start held high: one accept every 10 cycles, A/B changes in RUN ignored
        A = 8'd3; B = 8'd5; start = 1'b1;
        tick();
        A = 8'hAA; B = 8'h55;
        wait_done(n);
        check("b2b_first_latency", n[15:0], 16'd8);
        check("b2b_first_product", product, 16'h000F);
        A = 8'd6; B = 8'd7;
        tick();
        check("b2b_idle_gap_busy", {15'd0, busy}, 16'd0);
        tick();
        check("b2b_second_accept", {15'd0, busy}, 16'd1);
        A = 8'hFF; B = 8'hFF;
        wait_done(n);
        check("b2b_second_latency", n[15:0], 16'd8);
        check("b2b_second_product", product, 16'h002A);
        start = 1'b0;
        tick();
        tick();

        // reset during the 4th RUN cycle aborts with no done pulse
        A = 8'd7; B = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_busy_before", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_product", product, 16'h0000);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen[15:0], 16'd0);
        run_op("7x9", 8'd7, 8'd9, 16'h003F);

        // rst together with start: rst wins, start dropped
        A = 8'd2; B = 8'd3; start = 1'b1; rst = 1'b1;
        tick();
        start = 1'b0; rst = 1'b0;
        check("rst_start_busy", {15'd0, busy}, 16'd0);
        tick();
        check("rst_start_dropped", {15'd0, busy}, 16'd0);
        check("rst_start_product", product, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
